irq_ctrl: RTL

Machine-mode interrupt controller for the RV32I core's CSR unit. It sits directly downstream of the mie register:
- holds the mip register;
- synchronises the external and timer interrupt lines;
- gates pending interrupts with mie and mstatus.MIE;
- raises one prioritised trap request to the pipeline with a req/ack handshake.

Only M-mode sources are implemented. All S/U bits read as zero.

---
 rtl/irq_ctrl_pkg.sv | 36 +++
 rtl/irq_ctrl_if.sv | 32 +++
 rtl/irq_ctrl_sync.sv | 32 +++
 rtl/irq_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
//==============================================================================
// Module : rv_csr_pkg
// Brief  : Shared CSR constants, interrupt FSM state type and cause selection.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package rv_csr_pkg;

   localparam int MEI_BIT = 11;
   localparam int MTI_BIT = 7;
   localparam int MSI_BIT = 3;

   localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
   localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
   localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

   // Only the M-mode software, timer and external bits exist.
   localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      TAKEN = 2'd2
   } irq_state_t;

   // Priority MEI > MSI > MTI; only meaningful when pend is non-zero.
   function automatic logic [31:0] irq_cause_of(input logic [31:0] pend);
      if (pend[MEI_BIT])      return CAUSE_MEI;
      else if (pend[MSI_BIT]) return CAUSE_MSI;
      else                    return CAUSE_MTI;
   endfunction

endpackage

`default_nettype wire

// File: rtl/irq_ctrl_if.sv
//==============================================================================
// Module : irq_ctrl_if
// Brief  : CSR / pipeline side signals of the M-mode interrupt controller.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface irq_ctrl_if;
   logic [31:0] mie;
   logic        mstatus_mie;
   logic        ext_irq_in;
   logic        timer_irq_in;
   logic [31:0] mip_in;
   logic        wr_mip;
   logic        irq_ack;
   logic        mret;
   logic [31:0] mip;
   logic        irq_req;
   logic [31:0] irq_cause;

   modport master (
      output mie, mstatus_mie, ext_irq_in, timer_irq_in, mip_in, wr_mip, irq_ack, mret,
      input  mip, irq_req, irq_cause
   );

   modport slave (
      input  mie, mstatus_mie, ext_irq_in, timer_irq_in, mip_in, wr_mip, irq_ack, mret,
      output mip, irq_req, irq_cause
   );
endinterface

`default_nettype wire

// File: rtl/irq_ctrl_sync.sv
//==============================================================================
// Module : irq_sync
// Brief  : 1-bit two-flop synchroniser, asynchronous active-low reset.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module irq_sync (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic d,
   output logic      q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
//==============================================================================
// Module : irq_ctrl
// Brief  : M-mode interrupt controller: mip register, gating, prioritised
//          req/ack trap request. IRQ_SYNC_EN adds 2-flop input synchronisers.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module irq_ctrl
   import rv_csr_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  rst_n,
   irq_ctrl_if.slave  bus
);

   logic        w_meip;
   logic        w_mtip;
   logic        r_msip;
   logic [31:0] w_mip;
   logic [31:0] w_pend;
   logic        w_any_pend;

   irq_state_t  r_state;
   irq_state_t  w_state_nxt;
   logic        r_irq_req;
   logic        w_irq_req_nxt;
   logic [31:0] r_cause;
   logic [31:0] w_cause_nxt;

`ifdef IRQ_SYNC_EN
   // Second synchroniser stage is the architectural mip bit.
   irq_sync u_sync_ext (.clk(clk), .rst_n(rst_n), .d(bus.ext_irq_in),   .q(w_meip));
   irq_sync u_sync_tmr (.clk(clk), .rst_n(rst_n), .d(bus.timer_irq_in), .q(w_mtip));
`else
   logic r_meip;
   logic r_mtip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meip <= 1'b0;
         r_mtip <= 1'b0;
      end else begin
         r_meip <= bus.ext_irq_in;
         r_mtip <= bus.timer_irq_in;
      end
   end

   assign w_meip = r_meip;
   assign w_mtip = r_mtip;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_msip <= 1'b0;
      else if (bus.wr_mip) r_msip <= bus.mip_in[MSI_BIT];
   end

   assign w_mip      = {20'b0, w_meip, 3'b0, w_mtip, 3'b0, r_msip, 3'b0};
   assign w_pend     = w_mip & bus.mie & IRQ_MASK;
   assign w_any_pend = |w_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_irq_req <= 1'b0;
         r_cause   <= 32'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_irq_req <= w_irq_req_nxt;
         r_cause   <= w_cause_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      case (r_state)
         IDLE: begin
            if (bus.mstatus_mie && w_any_pend) begin
               w_state_nxt = REQ;
               w_cause_nxt = irq_cause_of(w_pend);
            end
         end
         REQ: begin
            // Ack has priority over withdrawal; cause stays frozen while pending.
            if (bus.irq_ack)                             w_state_nxt = TAKEN;
            else if (!w_any_pend || !bus.mstatus_mie)    w_state_nxt = IDLE;
         end
         TAKEN: begin
            if (bus.mret) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      w_irq_req_nxt = (w_state_nxt == REQ);
   end

   assign bus.mip       = w_mip;
   assign bus.irq_req   = r_irq_req;
   assign bus.irq_cause = r_cause;

   logic w_unused;
   assign w_unused = ^{bus.mie, bus.mip_in};

endmodule

`default_nettype wire
